// File: rtl/mem_stage_pkg.sv
// Shared widths and payload layouts for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_FWD_WD = 38;

    // Payload from execute: {res_from_mem, gr_we, dest, alu_result, pc}
    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // Payload to writeback: {gr_we, dest, final_result, pc}
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // Bypass bundle to decode: {valid, dest, data}
    typedef struct packed {
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] data;
    } ms_fwd_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, captures one-cycle SRAM
// read data for loads, holds it across writeback stalls, and feeds a
// bypass bus back to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_fwd_valid,
    output logic [4:0]                 ms_fwd_dest,
    output logic [31:0]                ms_fwd_data
);

    logic      ms_valid_q,    ms_valid_d;
    logic      first_cycle_q, first_cycle_d;
    es_to_ms_t es_bus_q,      es_bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic        accept;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_fwd_t     fwd;

    // Handshake and next-state for the valid bit and the latched payload.
    always_comb begin
        ms_ready_go = 1'b1;
        ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
        accept      = es_to_ms_valid && ms_allowin;

        ms_valid_d  = ms_valid_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        es_bus_d = es_bus_q;
        if (accept) begin
            es_bus_d = es_to_ms_bus;
        end
    end

    // Control state: synchronous reset discards any held instruction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            ms_valid_q    <= 1'b0;
            first_cycle_q <= 1'b0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            first_cycle_q <= first_cycle_d;
        end
    end

    // Payload registers: no reset, since nothing observes them while ms_valid_q is low.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are deliberately left unreset; resetting them only adds reset fan-out.
        es_bus_q    <= es_bus_d;
        rdata_buf_q <= rdata_buf_d;
    end

    // Load-data hold: SRAM data is live only in the first cycle, so buffer it for stalls.
    always_comb begin
        // first_cycle re-arms on every accept, including a back-to-back replacement.
        first_cycle_d = accept;

        rdata_buf_d = rdata_buf_q;
        if (ms_valid_q && first_cycle_q && es_bus_q.res_from_mem) begin
            rdata_buf_d = data_sram_rdata;
        end

        // NOTE: every branch assigns final_result, so no latch is inferred.
        if (!es_bus_q.res_from_mem) begin
            final_result = es_bus_q.alu_result;
        end else if (first_cycle_q) begin
            final_result = data_sram_rdata;
        end else begin
            final_result = rdata_buf_q;
        end
    end

    // Writeback payload and bypass outputs, forced to zero while the stage is empty.
    always_comb begin
        ws_bus = '0;
        fwd    = '0;
        if (ms_valid_q) begin
            ws_bus.gr_we        = es_bus_q.gr_we;
            ws_bus.dest         = es_bus_q.dest;
            ws_bus.final_result = final_result;
            ws_bus.pc           = es_bus_q.pc;
            fwd.valid           = es_bus_q.gr_we && (es_bus_q.dest != 5'd0);
            fwd.dest            = es_bus_q.dest;
            fwd.data            = final_result;
        end
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        ms_to_ws_bus   = ws_bus;
        ms_fwd_valid   = fwd.valid;
        ms_fwd_dest    = fwd.dest;
        ms_fwd_data    = fwd.data;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a small handshake model plus a queue of
// expected writeback payloads, compared when the stage hands an instruction over.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_fwd_valid    (ms_fwd_valid),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_data     (ms_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [69:0] exp_q[$];
    logic        m_valid   = 1'b0;
    logic        pend_load = 1'b0;

    task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [70:0] mk(input logic rfm, input logic we, input logic [4:0] dst,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {rfm, we, dst, alu, pc};
    endfunction

    // One clock cycle: drive inputs after the edge, check settled outputs, advance the model.
    task automatic tick(input logic rst, input logic v, input logic [70:0] b,
                        input logic ws, input logic [31:0] rd, input string tag);
        logic [69:0] e;
        logic        m_allow;
        @(posedge clk);
        #1;
        reset = rst; es_to_ms_valid = v; es_to_ms_bus = b;
        ws_allowin = ws; data_sram_rdata = rd;
        // The load accepted last edge receives its data in this cycle.
        if (pend_load && exp_q.size() > 0) begin
            e = exp_q[exp_q.size()-1];
            e[63:32] = rd;
            exp_q[exp_q.size()-1] = e;
        end
        pend_load = 1'b0;
        #1;
        m_allow = !m_valid || ws;
        check({tag, ".allowin"}, 70'(ms_allowin), 70'(m_allow));
        check({tag, ".valid"},   70'(ms_to_ws_valid), 70'(m_valid));
        if (!m_valid) begin
            check({tag, ".idle_bus"}, ms_to_ws_bus, 70'd0);
            check({tag, ".idle_fwd"}, 70'(ms_fwd_valid), 70'd0);
        end else if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 70'd1, 70'd0);
        end else begin
            e = exp_q[0];
            check({tag, ".fwd_valid"}, 70'(ms_fwd_valid), 70'(e[69] && (e[68:64] != 5'd0)));
            check({tag, ".fwd_data"},  70'(ms_fwd_data),  70'(e[63:32]));
            check({tag, ".fwd_dest"},  70'(ms_fwd_dest),  70'(e[68:64]));
            if (ws) begin
                e = exp_q.pop_front();
                check({tag, ".ws_bus"}, ms_to_ws_bus, e);
            end
        end
        // Advance the model to the state after the coming edge.
        if (rst) begin
            m_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (v && m_allow) begin
                exp_q.push_back({b[69], b[68:64], b[63:32], b[31:0]});
                pend_load = b[70];
            end
            if (m_allow) m_valid = v;
        end
    endtask

    localparam logic [31:0] PC0 = 32'hBFC0_0000;

    initial begin
        reset = 1'b1; es_to_ms_valid = 1'b1; ws_allowin = 1'b1;
        es_to_ms_bus = mk(1'b0, 1'b1, 5'd7, 32'h5555, PC0);
        data_sram_rdata = 32'h0;

        // 1: reset held two cycles with a valid instruction presented
        tick(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd7, 32'h5555, PC0), 1'b1, 32'h0, "rst0");
        tick(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd7, 32'h5555, PC0), 1'b1, 32'h0, "rst1");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "rst2");

        // 2: ALU op
        tick(1'b0, 1'b1, mk(1'b0, 1'b1, 5'd3, 32'h1234, PC0), 1'b1, 32'h0, "alu_in");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "alu_out");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "alu_drain");

        // 3: load without stall
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd4, 32'h0000_1000, PC0 + 4), 1'b1, 32'h0, "ld_in");
        tick(1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF, "ld_out");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "ld_drain");

        // 4: load stalled three cycles, SRAM data changes after the first cycle
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd5, 32'h0000_2000, PC0 + 8), 1'b1, 32'h0, "st_in");
        tick(1'b0, 1'b0, '0, 1'b0, 32'hCAFE_0001, "st_c1");
        tick(1'b0, 1'b1, mk(1'b0, 1'b1, 5'd9, 32'h9999, PC0 + 12), 1'b0, 32'hFFFF_FFFF, "st_c2");
        tick(1'b0, 1'b1, mk(1'b0, 1'b1, 5'd9, 32'h9999, PC0 + 12), 1'b0, 32'hFFFF_FFFF, "st_c3");
        tick(1'b0, 1'b1, mk(1'b0, 1'b1, 5'd9, 32'h9999, PC0 + 12), 1'b1, 32'hFFFF_FFFF, "st_go");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "st_next");

        // 5: back-to-back loads A then B
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd10, 32'h3000, PC0 + 16), 1'b1, 32'h0, "bb_a");
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd11, 32'h3004, PC0 + 20), 1'b1, 32'h1, "bb_b");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h2, "bb_out");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "bb_drain");

        // dest==0 write: no forwarding, gr_we still carried to writeback
        tick(1'b0, 1'b1, mk(1'b0, 1'b1, 5'd0, 32'h7777, PC0 + 24), 1'b1, 32'h0, "z_in");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "z_out");

        // 6: reset during a stalled load, then a fresh load
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd12, 32'h4000, PC0 + 28), 1'b1, 32'h0, "rs_in");
        tick(1'b0, 1'b0, '0, 1'b0, 32'hAAAA_0000, "rs_c1");
        tick(1'b1, 1'b1, mk(1'b0, 1'b1, 5'd13, 32'h5000, PC0 + 32), 1'b0, 32'h0, "rs_rst");
        tick(1'b0, 1'b1, mk(1'b1, 1'b1, 5'd14, 32'h6000, PC0 + 36), 1'b0, 32'h0, "rs_new");
        tick(1'b0, 1'b0, '0, 1'b0, 32'h1357_2468, "rs_first");
        tick(1'b0, 1'b0, '0, 1'b0, 32'h0BAD_0BAD, "rs_hold");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0BAD_0BAD, "rs_go");
        tick(1'b0, 1'b0, '0, 1'b1, 32'h0, "rs_drain");

        check("sb_left", 70'(exp_q.size()), 70'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
